// File: rtl/mdu_seq_unit_pkg.sv
// Shared types for the iterative RV32M multiply/divide unit: funct3 decode,
// FSM states and the per-operand signedness helper.
package mdu_seq_unit_pkg;

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } funct3_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef struct packed {
        logic sa;
        logic sb;
    } sign_sel_t;

    function automatic logic op_is_div(input logic [2:0] f);
        return f[2];
    endfunction

    function automatic logic op_is_rem(input logic [2:0] f);
        return f[2] & f[1];
    endfunction

    // MUL low bits are sign-agnostic, so it is handled as unsigned.
    function automatic sign_sel_t op_signs(input logic [2:0] f);
        sign_sel_t s;
        s.sa = (f == F3_MULH) || (f == F3_MULHSU) || (f == F3_DIV) || (f == F3_REM);
        s.sb = (f == F3_MULH) || (f == F3_DIV) || (f == F3_REM);
        return s;
    endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate; turns a signed value into a magnitude
// and a magnitude back into a signed result.
module mdu_sign_fix #(
    parameter int W = 33
) (
    input  logic [W-1:0] value,
    input  logic         negate,
    output logic [W-1:0] fixed
);

    assign fixed = negate ? (~value + 1'b1) : value;

endmodule

// File: rtl/mdu_seq_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// start/done handshake with pipeline stall and flush.
module mdu_seq_unit
    import mdu_seq_unit_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int MUL_UNROLL = 1,
    parameter bit FAST_SPEC  = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(XLEN / MUL_UNROLL - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(XLEN - 1);

    state_e          state;
    funct3_e         op_q;
    logic            sa_q;
    logic            sb_q;
    logic            dz_q;
    logic [CNT_W-1:0] cnt;
    // Shared datapath: hi = partial product / remainder, lo = multiplier / quotient.
    logic [XLEN-1:0] acc_hi;
    logic [XLEN-1:0] acc_lo;
    logic [XLEN-1:0] opnd;

    logic [2:0]      f3;
    sign_sel_t       sgn;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN:0]   a_mag;
    logic [XLEN:0]   b_mag;
    logic            is_div;
    logic            is_rem;
    logic            b_zero;
    logic            ovf;
    logic            special;
    logic [XLEN-1:0] spec_res;
    logic            accept_state;
    logic            last_step;

    assign f3     = inst[14:12];
    assign sgn    = op_signs(f3);
    assign is_div = op_is_div(f3);
    assign is_rem = op_is_rem(f3);
    assign a_neg  = sgn.sa & op_a[XLEN-1];
    assign b_neg  = sgn.sb & op_b[XLEN-1];

    wire unused_bits = ^{inst[31:15], inst[11:0], a_mag[XLEN], b_mag[XLEN]};

    // The extra bit lets -2^(XLEN-1) become an exact positive magnitude.
    mdu_sign_fix #(.W(XLEN + 1)) u_fix_a (
        .value  ({a_neg, op_a}),
        .negate (a_neg),
        .fixed  (a_mag)
    );

    mdu_sign_fix #(.W(XLEN + 1)) u_fix_b (
        .value  ({b_neg, op_b}),
        .negate (b_neg),
        .fixed  (b_mag)
    );

    assign b_zero  = (op_b == '0);
    assign ovf     = sgn.sb && (op_b == '1) && (op_a == {1'b1, {(XLEN-1){1'b0}}});
    assign special = is_div && (b_zero || ovf);

    always_comb begin
        spec_res = is_rem ? '0 : op_a;
        if (b_zero) begin
            spec_res = is_rem ? op_a : '1;
        end
    end

    assign accept_state = (state == ST_IDLE) || (state == ST_DONE);
    assign stall        = busy || (start && accept_state);

    // One iteration step: UNROLL shift-add bits in MUL, one restoring bit in DIV.
    logic [XLEN-1:0] hi_nxt;
    logic [XLEN-1:0] lo_nxt;
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        hi_nxt    = acc_hi;
        lo_nxt    = acc_lo;
        mul_sum   = '0;
        div_shift = '0;
        if (state == ST_MUL) begin
            for (int i = 0; i < MUL_UNROLL; i++) begin
                mul_sum = {1'b0, hi_nxt} + (lo_nxt[0] ? {1'b0, opnd} : '0);
                hi_nxt  = mul_sum[XLEN:1];
                lo_nxt  = {mul_sum[0], lo_nxt[XLEN-1:1]};
            end
        end else if (state == ST_DIV) begin
            div_shift = {acc_hi, acc_lo[XLEN-1]};
            if (div_shift >= {1'b0, opnd}) begin
                hi_nxt = XLEN'(div_shift - {1'b0, opnd});
                lo_nxt = {acc_lo[XLEN-2:0], 1'b1};
            end else begin
                hi_nxt = div_shift[XLEN-1:0];
                lo_nxt = {acc_lo[XLEN-2:0], 1'b0};
            end
        end
    end

    logic [2*XLEN-1:0] prod_fixed;
    logic [XLEN-1:0]   quot_fixed;
    logic [XLEN-1:0]   rem_fixed;
    logic [XLEN-1:0]   res_sel;

    mdu_sign_fix #(.W(2 * XLEN)) u_fix_prod (
        .value  ({hi_nxt, lo_nxt}),
        .negate (sa_q ^ sb_q),
        .fixed  (prod_fixed)
    );

    // A zero divisor yields an all-ones quotient whatever the dividend sign.
    mdu_sign_fix #(.W(XLEN)) u_fix_quot (
        .value  (lo_nxt),
        .negate ((sa_q ^ sb_q) & ~dz_q),
        .fixed  (quot_fixed)
    );

    mdu_sign_fix #(.W(XLEN)) u_fix_rem (
        .value  (hi_nxt),
        .negate (sa_q),
        .fixed  (rem_fixed)
    );

    always_comb begin
        res_sel = rem_fixed;
        case (op_q)
            F3_MUL:                       res_sel = prod_fixed[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: res_sel = prod_fixed[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              res_sel = quot_fixed;
            default:                      res_sel = rem_fixed;
        endcase
    end

    assign last_step = ((state == ST_MUL) && (cnt == MUL_LAST)) ||
                       ((state == ST_DIV) && (cnt == DIV_LAST));

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: datapath registers are cleared too, so a post-reset state is fully defined.
            state  <= ST_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            op_q   <= F3_MUL;
            sa_q   <= 1'b0;
            sb_q   <= 1'b0;
            dz_q   <= 1'b0;
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            opnd   <= '0;
        end else if (flush) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    if (start) begin
                        op_q <= funct3_e'(f3);
                        sa_q <= a_neg;
                        sb_q <= b_neg;
                        dz_q <= is_div & b_zero;
                        cnt  <= '0;
                        if (FAST_SPEC && special) begin
                            state  <= ST_DONE;
                            done   <= 1'b1;
                            result <= spec_res;
                        end else if (is_div) begin
                            state  <= ST_DIV;
                            busy   <= 1'b1;
                            acc_hi <= '0;
                            acc_lo <= a_mag[XLEN-1:0];
                            opnd   <= b_mag[XLEN-1:0];
                        end else begin
                            state  <= ST_MUL;
                            busy   <= 1'b1;
                            acc_hi <= '0;
                            acc_lo <= b_mag[XLEN-1:0];
                            opnd   <= a_mag[XLEN-1:0];
                        end
                    end
                end
                ST_MUL, ST_DIV: begin
                    acc_hi <= hi_nxt;
                    acc_lo <= lo_nxt;
                    if (last_step) begin
                        state  <= ST_DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        result <= res_sel;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
